key_event_encoder: RTL
======================

// Module: key_event_encoder
// PURPOSE
//  Producer side of the key interface. Samples the raw active-low board keys,
//  synchronises and debounces each key, and drives two outputs: a clean
//  stable key vector (same encoding as the raw pins) and a stream of encoded
//  press/release events over a valid/ready handshake. Downstream LED and
//  control logic consume these outputs instead of the raw pins.
// PARAMETERS
//  NKEYS        4           number of keys (evt_code width = clog2(NKEYS), min 1)
//  CLK_HZ       50_000_000  clk frequency in Hz
//  DEBOUNCE_MS  20          stable time required before a change is accepted
//  DB_CYCLES    derived     CLK_HZ/1000*DEBOUNCE_MS; must be >= 2
// PORTS
//  clk           in   1      system clock; the block's only clock
//  rst           in   1      reset, asynchronous, active-high
//  key_n         in   NKEYS  raw keys, active-low (0 = pressed), asynchronous
//  key_stable_n  out  NKEYS  debounced keys, active-low
//  evt_valid     out  1      event available
//  evt_ready     in   1      consumer accepts the event when valid&&ready
//  evt_code      out  CW     index of the key that changed (0 = key1)
//  evt_press     out  1      1 = press (1->0), 0 = release (0->1)
//  ovf_clr       in   1      clears the overflow flag
//  overflow      out  1      sticky: a key changed again before its event was sent
// BEHAVIOUR
//  - Reset: sync flops, key_stable_n = all 1s, counters = 0, pending = 0,
//    evt_valid = 0, evt_code = 0, evt_press = 0, overflow = 0.
//  - Sync: 2-flop synchroniser per key, reset to 1.
//  - Debounce, per key: if sync != stable, the counter increments. Otherwise
//    the counter clears. When the counter reaches DB_CYCLES-1 while still
//    differing, stable <= sync and the counter clears. Any single cycle of
//    agreement restarts the count. Counter width = clog2(DB_CYCLES).
//  - Latency: raw edge to key_stable_n change = 2 + DB_CYCLES clk.
//  - Pending: on a stable change of key i, pending[i] <= 1 and dir[i] <= press.
//    If pending[i] is already 1 in that cycle, dir[i] is overwritten and
//    overflow <= 1.
//  - Output FSM has two states:
//      IDLE: evt_valid = 0. If any pending bit is set, select the lowest set
//            index, load evt_code/evt_press, clear that pending bit, go to HOLD.
//      HOLD: evt_valid = 1. evt_code and evt_press hold stable until
//            valid&&ready. On acceptance, if another pending bit is set, load
//            it the same cycle and stay in HOLD (back-to-back, one event per
//            clk). Otherwise go to IDLE.
//  - Stable change to evt_valid = 1 clk when the output is idle.
//  - Simultaneous events in one cycle:
//      stable change of the key being loaded: pending stays set (new event);
//        the loaded event is the old one.
//      ovf_clr with a new overflow: set wins.
//  - evt_ready while evt_valid = 0 is ignored. Valid never drops without
//    acceptance, except on rst.
//  - Reset mid-operation: all pending events and any held event are discarded.
//    No event is generated for keys held down through reset until they are
//    released and pressed again. A release of such a key produces a release
//    event.
// STRUCTURE
//  - key_defs.vh (shared include): NKEYS default, clog2 function, EVT_PRESS and
//    EVT_RELEASE localparams. Downstream key consumers use the same file.
//  - Sub-module key_debounce_bit: synchroniser + counter + stable flop for one
//    key. Outputs stable_n and a one-cycle chg pulse. Instantiated NKEYS times
//    with a generate loop. The top level holds the pending/dir registers, the
//    arbiter, the output FSM and overflow.
// TESTING (CLK_HZ=1000, DEBOUNCE_MS=8 -> DB_CYCLES=8, NKEYS=4, evt_ready=1
//  unless stated otherwise)
//  1. key_n=1110 held -> key_stable_n=1110 at clk 10. Next clk:
//     evt_valid=1, code=0, press=1, for exactly 1 clk.
//  2. key1 bounces 0/1 every 3 clk for 40 clk, then stays 1 -> key_stable_n
//     never changes, no event.
//  3. key_n 1111->0000 in one cycle, evt_ready=0 for 20 clk, then 1 ->
//     events code 0,1,2,3, all press, on 4 consecutive clk. Code holds at 0
//     during the stall.
//  4. key2 press then release while evt_ready=0 and pending -> overflow=1.
//     One event is sent: code=1, press=0. ovf_clr pulse -> overflow=0.
//  5. rst asserted while evt_valid=1 and key3 held -> outputs return to reset
//     values at once. After release, evt code=2, press=0 only; no press event.
//  6. Random key_n stimulus against a reference model: events match stable
//     transitions in order. Assert valid/code stable under backpressure.

Source files
------------

// File: rtl/key_event_encoder_pkg.sv
// key_event_encoder_pkg
//   Shared definitions for the key interface. Downstream key consumers import
//   this package as well, so the event direction encoding lives here.
//   Contents: default key count, event direction constants, output FSM state
//   encodings and a ceiling-log2 helper that never returns less than 1.
package key_event_encoder_pkg;

  localparam int NKEYS_DEFAULT = 4;

  // Event direction carried on evt_press.
  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Output FSM state encodings.
  typedef logic [0:0] evt_state_t;
  localparam evt_state_t ST_IDLE = 1'b0;
  localparam evt_state_t ST_HOLD = 1'b1;

  // Bits needed to hold values 0..value-1, with a floor of 1 bit so that a
  // single key or a two-cycle debounce still gets a usable vector.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/key_event_encoder_if.sv
// key_event_encoder_if
//   Valid/ready event stream from the key encoder to its consumers.
//   Signals:
//     evt_valid  producer -> consumer  an event is being offered
//     evt_ready  consumer -> producer  event accepted when valid && ready
//     evt_code   producer -> consumer  index of the key that changed (0 = key1)
//     evt_press  producer -> consumer  1 = press, 0 = release
//   Modports: master (encoder side), slave (consumer side).
interface key_event_encoder_if #(
  parameter int CW = 2
);

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_code;
  logic          evt_press;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_press,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_press,
    output evt_ready
  );

endinterface

// File: rtl/key_event_encoder_debounce_bit.sv
// key_debounce_bit
//   Synchroniser, debounce counter and stable flop for a single raw key.
//   Ports:
//     clk, rst   system clock, asynchronous active-high reset
//     key_n      raw key, active-low, asynchronous to clk
//     stable_n   debounced key, active-low, resets to released
//     chg        one-cycle pulse in the cycle before stable_n flips
//     chg_press  direction of that flip (1 = becoming pressed)
module key_debounce_bit
  import key_event_encoder_pkg::*;
#(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable_n,
  output logic chg,
  output logic chg_press
);

  localparam int              CNTW     = clog2_min1(DB_CYCLES);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DB_CYCLES - 1);

  logic            sync_meta;
  logic            sync_n;
  logic            free_meta;
  logic            free_n;
  logic [CNTW-1:0] cnt;
  logic            held;
  logic            differ;
  logic            hit;

  // Two-flop synchroniser feeding the debouncer; parked at "released" in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_n    <= 1'b1;
    end else begin
      sync_meta <= key_n;
      sync_n    <= sync_meta;
    end
  end

  // Second synchroniser that keeps running through reset. It lets us tell,
  // right after reset, whether the key was already held down while reset was
  // asserted, which the reset-parked chain above cannot see.
  always_ff @(posedge clk) begin
    free_meta <= key_n;
    free_n    <= free_meta;
  end

  assign differ    = (sync_n != stable_n);
  assign hit       = differ && (cnt == CNT_LAST);
  assign chg_press = ~sync_n;

  // Count consecutive cycles of disagreement; a single agreeing cycle restarts
  // the count, and DB_CYCLES disagreeing samples in a row accept the change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      stable_n <= 1'b1;
    end else if (!differ) begin
      cnt <= '0;
    end else if (hit) begin
      cnt      <= '0;
      stable_n <= sync_n;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // held marks a key that was down across reset. It is dropped as soon as the
  // free-running sample shows the key released, so a key released during
  // reset clears it on the first clock after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 1'b1;
    end else if (free_n) begin
      held <= 1'b0;
    end
  end

  // The press of a key held through reset still updates stable_n but raises
  // no event; its later release does.
  assign chg = hit && !(chg_press && held);

endmodule

// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Producer side of the key interface: debounces the raw active-low keys and
//   turns every accepted change into a press/release event on a valid/ready
//   stream.
//   Parameters: NKEYS, CLK_HZ, DEBOUNCE_MS (DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS,
//   must be at least 2).
//   Ports:
//     clk, rst      system clock, asynchronous active-high reset
//     key_n         raw keys, active-low, asynchronous
//     key_stable_n  debounced keys, active-low
//     evt           event stream (master modport of key_event_encoder_if)
//     ovf_clr       clears overflow
//     overflow      sticky: a key changed again before its event was sent
module key_event_encoder
  import key_event_encoder_pkg::*;
#(
  parameter int NKEYS       = NKEYS_DEFAULT,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NKEYS-1:0]     key_n,
  output logic [NKEYS-1:0]     key_stable_n,
  key_event_encoder_if.master  evt,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int CW        = clog2_min1(NKEYS);

  logic [NKEYS-1:0] chg;
  logic [NKEYS-1:0] chg_press;
  logic [NKEYS-1:0] pending;
  logic [NKEYS-1:0] dir;
  logic [NKEYS-1:0] take;
  logic [CW-1:0]    pick_idx;
  logic             pick_dir;
  logic             found;
  logic             load;
  evt_state_t       state;
  logic [CW-1:0]    code_q;
  logic             press_q;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .key_n     (key_n[g]),
      .stable_n  (key_stable_n[g]),
      .chg       (chg[g]),
      .chg_press (chg_press[g])
    );
  end

  // Fixed-priority arbiter: lowest pending index wins.
  always_comb begin
    pick_idx = '0;
    pick_dir = EVT_RELEASE;
    found    = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (pending[i] && !found) begin
        pick_idx = CW'(i);
        pick_dir = dir[i];
        found    = 1'b1;
      end
    end
  end

  // A new event is loaded from IDLE, or in HOLD on the same cycle the current
  // one is accepted, which gives back-to-back events at one per clock.
  assign load = found && ((state == ST_IDLE) || evt.evt_ready);

  always_comb begin
    take = '0;
    if (load) begin
      take[pick_idx] = 1'b1;
    end
  end

  // The chg pulse arrives the cycle before stable_n flips, so pending is set on
  // the same edge as the stable change. A change on a key being loaded keeps
  // its pending bit set as a fresh event while the old direction goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      dir      <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~take) | chg;
      dir     <= (dir & ~chg) | (chg & chg_press);
      if (|(chg & pending)) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Output FSM: code/press only move on a load, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      code_q  <= '0;
      press_q <= EVT_RELEASE;
    end else if (load) begin
      state   <= ST_HOLD;
      code_q  <= pick_idx;
      press_q <= pick_dir;
    end else if ((state == ST_HOLD) && evt.evt_ready) begin
      state <= ST_IDLE;
    end
  end

  assign evt.evt_valid = (state == ST_HOLD);
  assign evt.evt_code  = code_q;
  assign evt.evt_press = press_q;

endmodule
